// File: rtl/vn_beta_buffer.sv
// Frame buffer for NBANK*DEPTH beta messages: bank-major write, bank-major read, or entry-major
// read when VN_TRANSPOSE_EN is defined. Read path is 1-cycle memory + output register + one-entry skid.
module vn_beta_buffer #(
   parameter int W     = 6,
   parameter int NBANK = 768,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic         busy,
   output logic         done
);
   localparam int TOTAL = NBANK * DEPTH;
   localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic [CW-1:0] rd_addr;
   logic [W-1:0]  mem [TOTAL];
   logic [W-1:0]  rd_dat_q;
   logic          rd_pend_q;
   logic          out_vld_q, out_vld_d;
   logic [W-1:0]  out_dat_q, out_dat_d;
   logic          skid_vld_q, skid_vld_d;
   logic [W-1:0]  skid_dat_q, skid_dat_d;
   logic          wr_beat, rd_issue, pop, last_pop;
   logic [1:0]    occ_after;

   assign in_ready  = (state_q == S_LOAD);
   assign wr_beat   = in_valid && in_ready;
   assign pop       = out_vld_q && out_ready;
   assign out_valid = out_vld_q;
   assign out_data  = out_dat_q;
   assign busy      = (state_q != S_IDLE);

   // Beats held or in flight after this cycle's pop; a new read is issued only if it still fits.
   assign occ_after = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(rd_pend_q) - 2'(pop);
   assign rd_issue  = (state_q == S_READ) && (occ_after < 2'd2);
   assign last_pop  = (state_q == S_FLUSH) && pop && !skid_vld_q && !rd_pend_q;
   assign done      = last_pop;

`ifdef VN_TRANSPOSE_EN
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam int EW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [BW-1:0] rd_bank_q, rd_bank_d;
   logic [EW-1:0] rd_ent_q, rd_ent_d;

   assign rd_addr = CW'(rd_bank_q) * CW'(DEPTH) + CW'(rd_ent_q);

   always_comb begin
      rd_bank_d = rd_bank_q;
      rd_ent_d  = rd_ent_q;
      if (rd_issue) begin
         if (rd_cnt_q == LAST) begin
            rd_bank_d = '0;
            rd_ent_d  = '0;
         end else if (rd_bank_q == BW'(NBANK - 1)) begin
            rd_bank_d = '0;
            rd_ent_d  = rd_ent_q + EW'(1);
         end else begin
            rd_bank_d = rd_bank_q + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_bank_q <= '0;
         rd_ent_q  <= '0;
      end else begin
         rd_bank_q <= rd_bank_d;
         rd_ent_q  <= rd_ent_d;
      end
   end
`else
   assign rd_addr = rd_cnt_q;
`endif

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD: begin
            if (wr_beat) begin
               if (wr_cnt_q == LAST) begin
                  wr_cnt_d = '0;
                  state_d  = S_READ;
               end else begin
                  wr_cnt_d = wr_cnt_q + CW'(1);
               end
            end
         end
         S_READ: begin
            if (rd_issue) begin
               if (rd_cnt_q == LAST) begin
                  rd_cnt_d = '0;
                  state_d  = S_FLUSH;
               end else begin
                  rd_cnt_d = rd_cnt_q + CW'(1);
               end
            end
         end
         S_FLUSH: if (last_pop) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Skid holds a beat only while the output register is occupied and stalled.
   always_comb begin
      out_vld_d  = out_vld_q;
      out_dat_d  = out_dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (!out_vld_q || pop) begin
         if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_dat_d  = skid_dat_q;
            skid_vld_d = rd_pend_q;
            skid_dat_d = rd_dat_q;
         end else if (rd_pend_q) begin
            out_vld_d = 1'b1;
            out_dat_d = rd_dat_q;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (rd_pend_q) begin
         skid_vld_d = 1'b1;
         skid_dat_d = rd_dat_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         rd_pend_q  <= 1'b0;
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         skid_vld_q <= 1'b0;
         skid_dat_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_pend_q  <= rd_issue;
         out_vld_q  <= out_vld_d;
         out_dat_q  <= out_dat_d;
         skid_vld_q <= skid_vld_d;
         skid_dat_q <= skid_dat_d;
      end
   end

   // Storage is deliberately outside reset so contents survive it.
   always_ff @(posedge clk) begin
      if (wr_beat) mem[wr_cnt_q] <= in_data;
      if (rd_issue) rd_dat_q <= mem[rd_addr];
   end

endmodule

// File: doc/vn_beta_buffer.md
VN_BETA_BUFFER -- requirements
Module: vn_beta_buffer

Interface
REQ-001 SHALL have parameter W, default 6, beta message width in bits.
REQ-002 SHALL have parameter NBANK, default 768, number of memory banks (one per variable node).
REQ-003 SHALL have parameter DEPTH, default 16, entries per bank.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a frame.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_data  input  W  beta value being written.
REQ-009 SHALL have port in_ready  output  1  buffer accepts in_data this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_data  output  W  beta value being read.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last output beat is accepted.

Function
REQ-015 SHALL implement states IDLE, LOAD, READ, FLUSH; reset state IDLE.
REQ-016 SHALL move IDLE->LOAD on start; start SHALL be ignored in all other states.
REQ-017 SHALL assert in_ready only in LOAD; a write beat is in_valid&&in_ready.
REQ-018 SHALL store write beat k (0..NBANK*DEPTH-1) at bank k/DEPTH, entry k%DEPTH (bank-major fill).
REQ-019 SHALL move LOAD->READ in the cycle the beat NBANK*DEPTH-1 is accepted; no further beat accepted that cycle.
REQ-020 SHALL use synchronous-read memory, 1-cycle read latency; first out_valid no later than 2 cycles after entering READ.
REQ-021 SHALL hold out_data stable while out_valid&&!out_ready; no beat dropped or duplicated under arbitrary out_ready patterns (output register plus one-entry skid).
REQ-022 SHALL sustain one output beat per cycle while out_ready is high.
REQ-023 SHALL move READ->FLUSH once all NBANK*DEPTH reads are issued, and FLUSH->IDLE with done=1 in the cycle the last beat is accepted.
REQ-024 SHALL size counters $clog2(NBANK*DEPTH) bits; address counters wrap to 0 at frame end, never past NBANK*DEPTH-1.
REQ-025 SHALL not modify memory on reads; contents persist across frames and reset.
REQ-026 SHALL accept a start pulse in the cycle after done (back-to-back frames).

Reset
REQ-027 SHALL on reset force state IDLE, counters 0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, skid empty.
REQ-028 SHALL on reset mid-LOAD or mid-READ abort the frame with no done pulse; memory contents undefined-but-unchanged.

Configuration
REQ-029 With VN_TRANSPOSE_EN defined, SHALL read entry-major: read beat j returns bank j%NBANK, entry j/NBANK (all banks at entry 0, then entry 1, ...).
REQ-030 Without VN_TRANSPOSE_EN, SHALL read bank-major in write order: read beat j returns write beat j.

Verification (NBANK=4, DEPTH=4, W=6)
REQ-031 start, write in_data=k for k=0..15, out_ready=1, no macro -> out_data 0,1,...,15 in order, done once after beat 15.
REQ-032 Same stimulus with VN_TRANSPOSE_EN -> out_data 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
REQ-033 out_ready toggling 1,0,0,1 repeating -> same sequence as REQ-031/032, out_data stable during stalls, 16 beats exactly.
REQ-034 in_valid low every other cycle in LOAD -> in_ready stays high, 16 beats stored, READ entered after 16th accepted beat only.
REQ-035 reset asserted after write beat 7 -> all outputs 0 next edge, state IDLE, no done; new frame then reads 16 correct values.
REQ-036 start pulsed during LOAD/READ -> no effect; start one cycle after done -> second frame data 63..48 read back correctly.
